// File: rtl/tinyqv_mem_pkg.sv
// Shared types for the TinyQV memory arbiter: FSM state encoding and mem_len codes.
package tinyqv_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_INSTR_RUN  = 3'd1,
        ST_INSTR_STOP = 3'd2,
        ST_DATA       = 3'd3,
        ST_DATA_DONE  = 3'd4
    } arb_state_t;

    localparam logic [1:0] LEN_BYTE   = 2'b00;
    localparam logic [1:0] LEN_HALF   = 2'b01;
    localparam logic [1:0] LEN_WORD   = 2'b10;
    localparam logic [1:0] LEN_STREAM = 2'b11;

    // A pending write wins over a read when both are (illegally) raised together.
    function automatic logic [1:0] request_len(input logic [1:0] read_n, input logic [1:0] write_n);
        return (write_n != 2'b11) ? write_n : read_n;
    endfunction

endpackage

// File: rtl/tinyqv_mem_arbiter.sv
// Arbitrates the TinyQV instruction stream and data accesses onto one memory controller.
// Optional TINYQV_MEM_ARB_FAIRNESS_EN guarantees MIN_INSTR_BEATS beats after a data access.
module tinyqv_mem_arbiter
    import tinyqv_mem_pkg::*;
#(
    parameter int ADDR_W          = 24,
    parameter int MIN_INSTR_BEATS = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [22:0]       instr_addr,
    input  logic              instr_fetch_restart,
    input  logic              instr_fetch_stall,
    output logic              instr_fetch_started,
    output logic              instr_fetch_stopped,
    output logic [15:0]       instr_data_in,
    output logic              instr_ready,

    input  logic [24:0]       data_addr,
    input  logic [1:0]        data_write_n,
    input  logic [1:0]        data_read_n,
    input  logic [31:0]       data_out,
    output logic              data_ready,
    output logic [31:0]       data_in,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_start,
    output logic              mem_is_write,
    output logic [1:0]        mem_len,
    output logic [31:0]       mem_wdata,
    output logic              mem_stop,
    input  logic              mem_busy,
    input  logic              mem_beat,
    input  logic [31:0]       mem_rdata
);

    arb_state_t  state;
    logic        data_req;
    logic        req_is_write;
    logic [1:0]  req_len;
    logic        start_data;
    logic        start_stream;
    logic        data_may_preempt;
    logic        stop_stream;
    logic [31:0] data_addr_ext;
    logic [31:0] instr_addr_ext;
    logic        unused_addr_bits;

    assign data_req      = (data_read_n != 2'b11) || (data_write_n != 2'b11);
    assign req_is_write  = (data_write_n != 2'b11);
    assign req_len       = request_len(data_read_n, data_write_n);

    // Nothing new is launched while the controller is still draining a previous transaction.
    assign start_data    = (state == ST_IDLE) && !mem_busy && data_req;
    assign start_stream  = (state == ST_IDLE) && !mem_busy && !data_req &&
                           instr_fetch_restart && !instr_fetch_stall;
    assign stop_stream   = instr_fetch_stall || instr_fetch_restart || (data_req && data_may_preempt);

    assign data_addr_ext    = 32'(data_addr);
    assign instr_addr_ext   = {8'b0, instr_addr, 1'b0};
    assign unused_addr_bits = &{1'b0, data_addr_ext[31:ADDR_W], instr_addr_ext[31:ADDR_W]};

`ifdef TINYQV_MEM_ARB_FAIRNESS_EN
    localparam int CNT_W = (MIN_INSTR_BEATS < 2) ? 1 : $clog2(MIN_INSTR_BEATS + 1);

    logic [CNT_W-1:0] beat_count;
    logic             guard_active;
    logic             after_data;

    assign data_may_preempt = !guard_active || (beat_count >= CNT_W'(MIN_INSTR_BEATS));

    // The stream launched right after a data access is protected until it has delivered enough beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count   <= '0;
            guard_active <= 1'b0;
            after_data   <= 1'b0;
        end else begin
            if ((state == ST_DATA_DONE) && !data_req && !mem_busy)
                after_data <= 1'b1;
            if (start_stream) begin
                guard_active <= after_data;
                after_data   <= 1'b0;
                beat_count   <= '0;
            end else if ((state == ST_INSTR_RUN) && mem_beat &&
                         (beat_count < CNT_W'(MIN_INSTR_BEATS))) begin
                beat_count <= beat_count + 1'b1;
            end
        end
    end
`else
    localparam int unused_min_beats = MIN_INSTR_BEATS;

    assign data_may_preempt = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= ST_IDLE;
            mem_start           <= 1'b0;
            mem_stop            <= 1'b0;
            instr_fetch_started <= 1'b0;
            instr_fetch_stopped <= 1'b0;
            instr_ready         <= 1'b0;
            data_ready          <= 1'b0;
            mem_len             <= LEN_STREAM;
            mem_is_write        <= 1'b0;
            mem_addr            <= '0;
            mem_wdata           <= '0;
        end else begin
            mem_start           <= 1'b0;
            mem_stop            <= 1'b0;
            instr_fetch_started <= 1'b0;
            instr_fetch_stopped <= 1'b0;
            instr_ready         <= 1'b0;
            data_ready          <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start_data) begin
                        mem_start    <= 1'b1;
                        mem_addr     <= data_addr_ext[ADDR_W-1:0];
                        mem_len      <= req_len;
                        mem_is_write <= req_is_write;
                        mem_wdata    <= data_out;
                        state        <= ST_DATA;
                    end else if (start_stream) begin
                        mem_start           <= 1'b1;
                        mem_addr            <= instr_addr_ext[ADDR_W-1:0];
                        mem_len             <= LEN_STREAM;
                        mem_is_write        <= 1'b0;
                        instr_fetch_started <= 1'b1;
                        state               <= ST_INSTR_RUN;
                    end
                end

                // A beat landing in the same cycle as the stop decision is still handed to the CPU.
                ST_INSTR_RUN: begin
                    instr_ready <= mem_beat;
                    if (stop_stream) begin
                        mem_stop <= 1'b1;
                        state    <= ST_INSTR_STOP;
                    end
                end

                // Wait one cycle for the controller to see mem_stop before trusting mem_busy.
                ST_INSTR_STOP: begin
                    if (!mem_busy && !mem_stop) begin
                        instr_fetch_stopped <= 1'b1;
                        state               <= ST_IDLE;
                    end
                end

                ST_DATA: begin
                    if (mem_beat) begin
                        data_ready <= 1'b1;
                        state      <= ST_DATA_DONE;
                    end
                end

                ST_DATA_DONE: begin
                    if (!data_req && !mem_busy)
                        state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state == ST_INSTR_RUN) && mem_beat)
            instr_data_in <= mem_rdata[15:0];
    end

    always_ff @(posedge clk) begin
        if ((state == ST_DATA) && mem_beat && !mem_is_write)
            data_in <= mem_rdata;
    end

endmodule
